// File: rtl/regbank_pkg.sv
// Shared definitions for the register-bank write side: index/data widths and
// the set of architecturally implemented register indices.
package regbank_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;

  // Bit n set means register rn physically exists in the bank (r0..r10, r25..r31).
  localparam logic [31:0] REG_IMPL_MASK = 32'hFE0007FF;

  // True when the given index maps to a physical register.
  function automatic logic reg_impl(input logic [REG_AW-1:0] idx);
    return REG_IMPL_MASK[idx];
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Writeback FIFO: holds accepted {rd, data} entries in acceptance order and
// exposes per-slot occupancy plus each slot's destination index so the top
// level can build the pending-destination mask.
module wb_fifo
  import regbank_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int W     = REG_AW + REG_DW
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              push_i,
  input  logic [W-1:0]                      push_data_i,
  input  logic                              pop_i,
  output logic [W-1:0]                      head_o,
  output logic                              full_o,
  output logic                              empty_o,
  output logic [$clog2(DEPTH):0]            level_o,
  output logic [DEPTH-1:0]                  occ_o,
  output logic [DEPTH-1:0][AW-1:0]          entry_rd_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [DEPTH-1:0] occ_q, occ_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign occ_o   = occ_q;

  // Next-state for pointers, occupancy bits and level; pointers wrap naturally
  // because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    level_d  = level_q;
    if (do_push) begin
      wr_ptr_d         = wr_ptr_q + PW'(1);
      occ_d[wr_ptr_q]  = 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d         = rd_ptr_q + PW'(1);
      occ_d[rd_ptr_q]  = 1'b0;
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Control state: reset empties the queue regardless of stored contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      occ_q    <= occ_d;
    end
  end

  // Entry storage; contents are only meaningful where occ_q is set.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Destination index of every slot, taken from the upper field of the entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_rd_o[i] = mem_q[i][W-1 -: AW];
    end
  end

endmodule

// File: rtl/regbank_wb_ctrl.sv
// Write-side controller for the register bank: arbitrates ALU and load
// writebacks, filters unimplemented destinations, queues accepted writes and
// retires one per cycle through a registered issue stage.
module regbank_wb_ctrl
  import regbank_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int DW       = REG_DW,
  parameter int AW       = REG_AW,
  parameter int PRIO_MEM = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [AW-1:0]          alu_rd,
  input  logic [DW-1:0]          alu_data,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [AW-1:0]          mem_rd,
  input  logic [DW-1:0]          mem_data,
  output logic                   wr_en,
  output logic [AW-1:0]          rd,
  output logic [DW-1:0]          i_data,
  output logic [31:0]            pend_mask,
  output logic                   drop_err,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int W = AW + DW;

  logic                    fifo_push, fifo_pop;
  logic [W-1:0]            fifo_head;
  logic                    fifo_full, fifo_empty;
  logic [DEPTH-1:0]        fifo_occ;
  logic [DEPTH-1:0][AW-1:0] fifo_entry_rd;

  logic                    acc_alu, acc_mem, accept;
  logic [AW-1:0]           sel_rd;
  logic [DW-1:0]           sel_data;
  logic                    sel_impl;

  logic                    wr_en_q, wr_en_d;
  logic [AW-1:0]           rd_q, rd_d;
  logic [DW-1:0]           data_q, data_d;
  logic                    drop_q, drop_d;

  wb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst),
    .push_i      (fifo_push),
    .push_data_i ({sel_rd, sel_data}),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level),
    .occ_o       (fifo_occ),
    .entry_rd_o  (fifo_entry_rd)
  );

  // Fixed-priority arbitration: the loser is only ready when the winner is idle.
  // Readiness looks at the current level only, so a full FIFO never accepts
  // on the strength of a same-cycle pop.
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (PRIO_MEM != 0) begin
      mem_ready = ~fifo_full;
      alu_ready = ~fifo_full & ~mem_valid;
    end else begin
      alu_ready = ~fifo_full;
      mem_ready = ~fifo_full & ~alu_valid;
    end
  end

  assign acc_alu  = alu_valid & alu_ready;
  assign acc_mem  = mem_valid & mem_ready;
  assign accept   = acc_alu | acc_mem;
  assign sel_rd   = acc_mem ? mem_rd   : alu_rd;
  assign sel_data = acc_mem ? mem_data : alu_data;
  assign sel_impl = reg_impl(REG_AW'(sel_rd));

  // Accepted writes to missing registers are swallowed and flagged instead of queued.
  assign fifo_push = accept & sel_impl;
  assign drop_d    = accept & ~sel_impl;

  // The issue stage drains the head whenever anything is queued.
  assign fifo_pop = ~fifo_empty;

  // Issue-stage next state: load the head on a pop, otherwise hold rd/data.
  always_comb begin
    wr_en_d = ~fifo_empty;
    rd_d    = rd_q;
    data_d  = data_q;
    if (!fifo_empty) begin
      rd_d   = fifo_head[W-1 -: AW];
      data_d = fifo_head[DW-1:0];
    end
  end

  // Issue stage and drop flag; reset clears everything so no stale write escapes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_q <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      wr_en_q <= wr_en_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign rd       = rd_q;
  assign i_data   = data_q;
  assign drop_err = drop_q;

  // Pending mask: every queued destination plus the one being written this cycle.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_occ[i]) begin
        pend_mask = pend_mask | (32'd1 << fifo_entry_rd[i]);
      end
    end
    if (wr_en_q) begin
      pend_mask = pend_mask | (32'd1 << rd_q);
    end
  end

endmodule
